mem_arbiter: RTL and testbench

- Shares the single slow, busy-handshaked memory between the instruction-fetch port (read-only) and the MEM-stage data port (load/store).
- Sits between the pipeline and the memory. Latches each granted request, holds it on the memory bus until the memory finishes, returns read data, and drives per-port stall signals to the hazard unit.
- Data port has fixed priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one busy-handshaked memory between the fetch port and the data port.
// The data port has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
//
// state  | meaning
// IDLE   | no op in flight, arbitrate on this edge
// BUSY_D | data op on the memory bus, waiting for busy to fall
// BUSY_I | fetch op on the memory bus, waiting for busy to fall
// RESP   | one-cycle completion, done pulse and read data valid
module mem_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDRWIDTH  = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 i_read_i,
   input  logic [ADDRWIDTH-1:0] i_addr_i,
   output logic [WIDTH-1:0]     i_rdata_o,
   output logic                 i_done_o,
   output logic                 i_stall_o,
   input  logic                 d_read_i,
   input  logic                 d_write_i,
   input  logic [ADDRWIDTH-1:0] d_addr_i,
   input  logic [WIDTH-1:0]     d_wdata_i,
   output logic [WIDTH-1:0]     d_rdata_o,
   output logic                 d_done_o,
   output logic                 d_stall_o,
   output logic                 mem_read_o,
   output logic                 mem_write_o,
   output logic [ADDRWIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0]     mem_wdata_o,
   input  logic                 mem_busy_i,
   input  logic [WIDTH-1:0]     mem_rdata_i,
   output logic                 err_o
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [7:0]    WD_LIM     = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [7:0]    wd_cnt;
   logic          seen_busy;
   logic          d_req;
   logic          grant_i;
   logic          complete;
   logic          wd_expired;
   logic [WIDTH-1:0] rdata_sel;

   assign d_req      = d_read_i | d_write_i;
   assign grant_i    = i_read_i && ((starve_cnt == STARVE_LIM) || !d_req);
   assign complete   = !mem_busy_i && seen_busy;
   assign wd_expired = (wd_cnt == WD_LIM);
   // A normal completion wins over a watchdog expiry on the same edge.
   assign rdata_sel  = complete ? mem_rdata_i : '0;

   assign i_stall_o = i_read_i & ~i_done_o;
   assign d_stall_o = d_req & ~d_done_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         wd_cnt      <= '0;
         seen_busy   <= 1'b0;
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         i_rdata_o   <= '0;
         d_rdata_o   <= '0;
         i_done_o    <= 1'b0;
         d_done_o    <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         i_done_o <= 1'b0;
         d_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state       <= BUSY_I;
                  mem_read_o  <= 1'b1;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= i_addr_i;
                  mem_wdata_o <= '0;
                  starve_cnt  <= '0;
               end else if (d_req) begin
                  state       <= BUSY_D;
                  mem_read_o  <= ~d_write_i;
                  mem_write_o <= d_write_i;
                  mem_addr_o  <= d_addr_i;
                  mem_wdata_o <= d_write_i ? d_wdata_i : '0;
                  if (d_read_i && d_write_i)
                     err_o <= 1'b1;
                  if (!i_read_i)
                     starve_cnt <= '0;
                  else if (starve_cnt != STARVE_LIM)
                     starve_cnt <= starve_cnt + SW'(1);
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY_D, BUSY_I: begin
               if (mem_busy_i)
                  seen_busy <= 1'b1;
               if (complete || wd_expired) begin
                  state       <= RESP;
                  mem_read_o  <= 1'b0;
                  mem_write_o <= 1'b0;
                  if (!complete)
                     err_o <= 1'b1;
                  if (state == BUSY_D) begin
                     d_done_o <= 1'b1;
                     if (!mem_write_o)
                        d_rdata_o <= rdata_sel;
                  end else begin
                     i_done_o  <= 1'b1;
                     i_rdata_o <= rdata_sel;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            RESP: begin
               state     <= IDLE;
               seen_busy <= 1'b0;
               wd_cnt    <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written arbitration, starvation, conflict, timeout and reset sequences.
module tb_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        i_read_i;
   logic [31:0] i_addr_i;
   logic [31:0] i_rdata_o;
   logic        i_done_o;
   logic        i_stall_o;
   logic        d_read_i;
   logic        d_write_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_done_o;
   logic        d_stall_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_busy_i = 1'b0;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   mem_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
      .i_done_o(i_done_o), .i_stall_o(i_stall_o),
      .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
      .d_stall_o(d_stall_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_busy_i(mem_busy_i), .mem_rdata_i(mem_rdata_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Memory model: busy for busy_n cycles after a strobe appears, or forever when stuck.
   logic [31:0] mem_arr [256];
   int          busy_n = 1;
   bit          stuck = 1'b0;
   bit          active = 1'b0;
   int          left = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_wdata = '0;

   assign mem_rdata_i = mem_arr[mem_addr_o[7:0]];

   always @(negedge clk_i) begin
      if (mem_read_o || mem_write_o) begin
         if (!active) begin
            active = 1'b1;
            left   = busy_n;
            if (mem_write_o) begin
               mem_arr[mem_addr_o[7:0]] = mem_wdata_o;
               wr_addr = mem_addr_o;
               wr_data = mem_wdata_o;
            end else begin
               rd_wdata = mem_wdata_o;
            end
         end
         if (stuck) mem_busy_i = 1'b1;
         else if (left > 0) begin
            mem_busy_i = 1'b1;
            left--;
         end else mem_busy_i = 1'b0;
      end else begin
         active     = 1'b0;
         mem_busy_i = 1'b0;
      end
   end

   typedef struct {
      bit          is_d;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          busy;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs [5];

   // Issues one request in IDLE, waits (bounded) for its done pulse, then drops it.
   task automatic run_txn(input bit is_d, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int busy, output int lat, output int stall_bad);
      bit got;
      @(posedge clk_i); #1;
      busy_n = busy;
      if (is_d) begin
         d_read_i = rd; d_write_i = wr; d_addr_i = addr; d_wdata_i = wdata;
      end else begin
         i_read_i = 1'b1; i_addr_i = addr;
      end
      got = 1'b0; lat = 0; stall_bad = 0;
      for (int k = 1; k <= 400 && !got; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (is_d ? d_done_o : i_done_o) begin
            got = 1'b1;
            lat = k;
            if (is_d ? d_stall_o : i_stall_o) stall_bad++;
         end else if (!(is_d ? d_stall_o : i_stall_o)) stall_bad++;
      end
      if (!got) begin
         total++;
         $display("FAIL txn_timeout: no done within 400 cycles (addr 0x%08h)", addr);
      end
      d_read_i = 1'b0; d_write_i = 1'b0; i_read_i = 1'b0;
   endtask

   int  lat, sbad, n, bad;
   bit  seq [6];
   bit  ok;

   initial begin
      vecs[0] = '{1, 1, 0, 32'h10, 32'h0,        4, 32'hDEADBEEF, 6};
      vecs[1] = '{1, 0, 1, 32'h20, 32'h12345678, 2, 32'hDEADBEEF, 4};
      vecs[2] = '{0, 1, 0, 32'h20, 32'h0,        3, 32'h12345678, 5};
      vecs[3] = '{0, 1, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 3};
      vecs[4] = '{1, 1, 0, 32'h20, 32'h0,        1, 32'h12345678, 3};

      for (int a = 0; a < 256; a++) mem_arr[a] = '0;
      mem_arr[8'h10] = 32'hDEADBEEF;

      rst_i = 1'b1;
      i_read_i = 0; i_addr_i = 0; d_read_i = 0; d_write_i = 0; d_addr_i = 0; d_wdata_i = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_mem_read", {31'b0, mem_read_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      check("rst_d_rdata", d_rdata_o, 32'd0);
      rst_i = 1'b0;

      for (int v = 0; v < 5; v++) begin
         run_txn(vecs[v].is_d, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                 vecs[v].busy, lat, sbad);
         check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
         check($sformatf("vec%0d_stall", v), sbad, 0);
         check($sformatf("vec%0d_rdata", v), vecs[v].is_d ? d_rdata_o : i_rdata_o, vecs[v].exp_rdata);
         if (vecs[v].wr) begin
            check($sformatf("vec%0d_wr_addr", v), wr_addr, vecs[v].addr);
            check($sformatf("vec%0d_wr_data", v), wr_data, vecs[v].wdata);
         end else begin
            check($sformatf("vec%0d_rd_wdata", v), rd_wdata, 32'd0);
         end
      end

      // Simultaneous requests: data first, fetch second, fetch stalled throughout.
      @(posedge clk_i); #1;
      busy_n = 2;
      d_read_i = 1'b1; d_addr_i = 32'h20;
      i_read_i = 1'b1; i_addr_i = 32'h10;
      n = 0; bad = 0;
      for (int k = 0; k < 100 && n < 2; k++) begin
         @(negedge clk_i);
         if (n == 0 && (d_done_o || i_done_o)) begin
            check("simul_first_d", {30'b0, d_done_o, i_done_o}, 32'd2);
            check("simul_d_rdata", d_rdata_o, 32'h12345678);
            check("simul_i_stall", {31'b0, i_stall_o}, 32'd1);
            d_read_i = 1'b0;
            n = 1;
         end else if (n == 1 && (d_done_o || i_done_o)) begin
            check("simul_second_i", {30'b0, d_done_o, i_done_o}, 32'd1);
            check("simul_i_rdata", i_rdata_o, 32'hDEADBEEF);
            i_read_i = 1'b0;
            n = 2;
         end else if (!i_stall_o) bad++;
      end
      check("simul_done_count", n, 2);
      check("simul_stall_gap", bad, 0);

      // Starvation: both held; expect D D D D I D.
      @(posedge clk_i); #1;
      busy_n = 1;
      d_read_i = 1'b1; d_addr_i = 32'h10;
      i_read_i = 1'b1; i_addr_i = 32'h20;
      n = 0;
      for (int k = 0; k < 200 && n < 6; k++) begin
         @(negedge clk_i);
         if (d_done_o) begin seq[n] = 1'b1; n++; end
         else if (i_done_o) begin seq[n] = 1'b0; n++; i_read_i = 1'b0; end
      end
      d_read_i = 1'b0; i_read_i = 1'b0;
      check("starve_done_count", n, 6);
      for (int s = 0; s < 6; s++)
         check($sformatf("starve_grant%0d_is_d", s), {31'b0, seq[s]}, (s == 4) ? 32'd0 : 32'd1);

      // Read and write together: treated as a write, error raised.
      check("err_before_conflict", {31'b0, err_o}, 32'd0);
      run_txn(1, 1, 1, 32'h30, 32'hA5A5A5A5, 2, lat, sbad);
      check("conflict_latency", lat, 4);
      check("conflict_wr_addr", wr_addr, 32'h30);
      check("conflict_wr_data", wr_data, 32'hA5A5A5A5);
      check("conflict_err", {31'b0, err_o}, 32'd1);

      // Watchdog: memory stuck busy.
      stuck = 1'b1;
      run_txn(1, 1, 0, 32'h10, 32'h0, 1, lat, sbad);
      stuck = 1'b0;
      check("timeout_latency", lat, 257);
      check("timeout_rdata", d_rdata_o, 32'd0);
      check("timeout_err", {31'b0, err_o}, 32'd1);
      repeat (3) @(posedge clk_i);
      #1;
      check("err_sticky", {31'b0, err_o}, 32'd1);

      // Reset during BUSY_D, then a clean fetch.
      @(posedge clk_i); #1;
      busy_n = 10;
      d_read_i = 1'b1; d_addr_i = 32'h10;
      repeat (3) @(posedge clk_i);
      #2;
      check("pre_reset_mem_read", {31'b0, mem_read_o}, 32'd1);
      rst_i = 1'b1;
      #1;
      check("reset_mem_read", {31'b0, mem_read_o}, 32'd0);
      check("reset_mem_addr", mem_addr_o, 32'd0);
      check("reset_err", {31'b0, err_o}, 32'd0);
      check("reset_d_done", {31'b0, d_done_o}, 32'd0);
      check("reset_i_rdata", i_rdata_o, 32'd0);
      d_read_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      run_txn(0, 1, 0, 32'h10, 32'h0, 2, lat, sbad);
      check("post_reset_latency", lat, 4);
      check("post_reset_rdata", i_rdata_o, 32'hDEADBEEF);
      check("post_reset_err", {31'b0, err_o}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
